// File: rtl/pc_pkg.sv
// Shared defaults and command-priority encoding for the program-counter block.
package pc_pkg;

    localparam int unsigned DEF_ADDR_W    = 8;
    localparam int unsigned DEF_STK_DEPTH = 4;
    localparam int unsigned DEF_RESET_VEC = 0;

    // One resolved command per cycle; enumerators listed lowest to highest priority.
    typedef enum logic [2:0] {
        CmdNone,
        CmdIpc,
        CmdJrel,
        CmdRet,
        CmdCall,
        CmdLpc
    } cmd_e;

    // Resolve simultaneous requests: LPC > CALL > RET > JREL > IPC.
    function automatic cmd_e pick_cmd(input logic lpc, input logic call, input logic ret,
                                      input logic jrel, input logic ipc);
        cmd_e c;
        if (lpc)       c = CmdLpc;
        else if (call) c = CmdCall;
        else if (ret)  c = CmdRet;
        else if (jrel) c = CmdJrel;
        else if (ipc)  c = CmdIpc;
        else           c = CmdNone;
        return c;
    endfunction

endpackage

// File: rtl/ret_stack.sv
// Register-based LIFO return-address stack. Only the count is reset; entries are
// don't-care until written. Callers must not push when full or pop when empty.
module ret_stack
    import pc_pkg::*;
#(
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned STK_DEPTH = DEF_STK_DEPTH,
    localparam int unsigned CNT_W    = $clog2(STK_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] data_in,
    output logic [ADDR_W-1:0] top,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    localparam int unsigned IDX_W = $clog2(STK_DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(STK_DEPTH);

    logic [ADDR_W-1:0] mem_q [STK_DEPTH];
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  top_cnt;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  top_idx;

    // Index decode: write at count, read at count-1 (wraps harmlessly when empty).
    always_comb begin
        top_cnt = count_q - 1'b1;
        wr_idx  = count_q[IDX_W-1:0];
        top_idx = top_cnt[IDX_W-1:0];
    end

    // Occupancy counter; push and pop are never asserted together by the parent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (push && !full) begin
            count_q <= count_q + 1'b1;
        end else if (pop && !empty) begin
            count_q <= count_q - 1'b1;
        end
    end

    // Entry storage, unreset.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_q[wr_idx] <= data_in;
        end
    end

    // Status and top-of-stack outputs.
    always_comb begin
        full  = (count_q == FULL_CNT);
        empty = (count_q == '0);
        top   = mem_q[top_idx];
        count = count_q;
    end

endmodule

// File: rtl/pc_stack.sv
// Program counter with increment, absolute load, relative jump, and call/return
// through a hardware return stack. Stack misuse sets a sticky error flag.
module pc_stack
    import pc_pkg::*;
#(
    parameter int unsigned       ADDR_W    = DEF_ADDR_W,
    parameter int unsigned       STK_DEPTH = DEF_STK_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(DEF_RESET_VEC)
) (
    input  logic              clk,
    input  logic              CLRn,
    input  logic              IPC,
    input  logic              LPC,
    input  logic              JREL,
    input  logic              CALL,
    input  logic              RET,
    input  logic [ADDR_W-1:0] D,
    input  logic [ADDR_W-1:0] OFS,
    output logic [ADDR_W-1:0] PC_addr,
    output logic              stk_full,
    output logic              stk_empty,
    output logic              stk_err
);

    localparam int unsigned CNT_W = $clog2(STK_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(STK_DEPTH);

    cmd_e              cmd;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic              err_q;
    logic              err_d;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] ret_addr;
    logic [ADDR_W-1:0] pc_inc;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  count;

    ret_stack #(
        .ADDR_W    (ADDR_W),
        .STK_DEPTH (STK_DEPTH)
    ) u_ret_stack (
        .clk     (clk),
        .rst     (CLRn),
        .push    (push),
        .pop     (pop),
        .data_in (pc_inc),
        .top     (ret_addr),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    // Resolve the winning command and compute next PC, stack strobes and error.
    always_comb begin
        cmd    = pick_cmd(LPC, CALL, RET, JREL, IPC);
        pc_inc = pc_q + 1'b1;
        pc_d   = pc_q;
        push   = 1'b0;
        pop    = 1'b0;
        err_d  = err_q;
        case (cmd)
            CmdLpc:  pc_d = D;
            CmdCall: begin
                if (full) begin
                    err_d = 1'b1;
                end else begin
                    push = 1'b1;
                    pc_d = D;
                end
            end
            CmdRet: begin
                if (empty) begin
                    err_d = 1'b1;
                end else begin
                    pop  = 1'b1;
                    pc_d = ret_addr;
                end
            end
            CmdJrel: pc_d = pc_q + OFS;
            CmdIpc:  pc_d = pc_inc;
            default: pc_d = pc_q;
        endcase
    end

    // PC and sticky error registers.
    always_ff @(posedge clk or posedge CLRn) begin
        if (CLRn) begin
            pc_q  <= RESET_VEC;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            err_q <= err_d;
        end
    end

    // Outputs; stack flags decode straight from the occupancy count.
    always_comb begin
        PC_addr   = pc_q;
        stk_err   = err_q;
        stk_full  = (count == FULL_CNT);
        stk_empty = (count == '0);
    end

endmodule

// File: tb/tb_pc_stack.sv
// Directed self-checking bench for pc_stack with default parameters.
module tb_pc_stack;

    logic       clk;
    logic       CLRn;
    logic       IPC, LPC, JREL, CALL, RET;
    logic [7:0] D, OFS;
    logic [7:0] PC_addr;
    logic       stk_full, stk_empty, stk_err;

    int passed;
    int total;

    pc_stack #(
        .ADDR_W    (8),
        .STK_DEPTH (4),
        .RESET_VEC (8'h00)
    ) dut (
        .clk       (clk),
        .CLRn      (CLRn),
        .IPC       (IPC),
        .LPC       (LPC),
        .JREL      (JREL),
        .CALL      (CALL),
        .RET       (RET),
        .D         (D),
        .OFS       (OFS),
        .PC_addr   (PC_addr),
        .stk_full  (stk_full),
        .stk_empty (stk_empty),
        .stk_err   (stk_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        IPC = 0; LPC = 0; JREL = 0; CALL = 0; RET = 0; D = 8'h00; OFS = 8'h00;
    endtask

    // Advance one rising edge and settle past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        CLRn = 1'b1;
        tick();
        CLRn = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        CLRn = 1'b1;
        tick();
        tick();
        total++; if (PC_addr !== 8'h00) $display("FAIL reset_pc got %h want 00", PC_addr); else passed++;
        total++; if (stk_empty !== 1'b1) $display("FAIL reset_empty got %b want 1", stk_empty); else passed++;
        total++; if (stk_full !== 1'b0) $display("FAIL reset_full got %b want 0", stk_full); else passed++;
        total++; if (stk_err !== 1'b0) $display("FAIL reset_err got %b want 0", stk_err); else passed++;
        CLRn = 1'b0;
    endtask

    task automatic test_ipc_wrap();
        logic [7:0] exp;
        do_reset();
        exp = 8'h00;
        total++; if (PC_addr !== exp) $display("FAIL ipc_start got %h want %h", PC_addr, exp); else passed++;
        IPC = 1;
        for (int i = 1; i < 260; i++) begin
            tick();
            exp = 8'(i % 256);
            total++;
            if (PC_addr !== exp || stk_err !== 1'b0)
                $display("FAIL ipc_step%0d got %h/%b want %h/0", i, PC_addr, stk_err, exp);
            else passed++;
        end
        idle();
        tick();
        total++; if (PC_addr !== 8'h03) $display("FAIL hold got %h want 03", PC_addr); else passed++;
    endtask

    task automatic test_jrel();
        do_reset();
        LPC = 1; D = 8'h10; tick(); idle();
        JREL = 1; OFS = 8'hFC; tick();
        total++; if (PC_addr !== 8'h0C) $display("FAIL jrel_neg got %h want 0c", PC_addr); else passed++;
        OFS = 8'h05; tick();
        total++; if (PC_addr !== 8'h11) $display("FAIL jrel_pos got %h want 11", PC_addr); else passed++;
        idle(); LPC = 1; D = 8'hFE; tick(); idle();
        JREL = 1; OFS = 8'h03; tick();
        total++; if (PC_addr !== 8'h01) $display("FAIL jrel_wrap got %h want 01", PC_addr); else passed++;
        OFS = 8'h00; tick();
        total++; if (PC_addr !== 8'h01) $display("FAIL jrel_zero got %h want 01", PC_addr); else passed++;
        idle();
    endtask

    task automatic test_call_ret();
        do_reset();
        LPC = 1; D = 8'h20; tick(); idle();
        CALL = 1; D = 8'h40; tick();
        total++; if (PC_addr !== 8'h40) $display("FAIL call1 got %h want 40", PC_addr); else passed++;
        D = 8'h60; tick();
        total++; if (PC_addr !== 8'h60) $display("FAIL call2 got %h want 60", PC_addr); else passed++;
        idle(); RET = 1; tick();
        total++; if (PC_addr !== 8'h41) $display("FAIL ret1 got %h want 41", PC_addr); else passed++;
        tick();
        total++; if (PC_addr !== 8'h21) $display("FAIL ret2 got %h want 21", PC_addr); else passed++;
        total++; if (stk_empty !== 1'b1) $display("FAIL cr_empty got %b want 1", stk_empty); else passed++;
        total++; if (stk_err !== 1'b0) $display("FAIL cr_err got %b want 0", stk_err); else passed++;
        idle();
    endtask

    task automatic test_overflow();
        logic [7:0] rets [4];
        rets[0] = 8'h31; rets[1] = 8'h21; rets[2] = 8'h11; rets[3] = 8'h01;
        do_reset();
        CALL = 1;
        for (int i = 1; i <= 4; i++) begin
            D = 8'(i * 16);
            tick();
        end
        total++; if (stk_full !== 1'b1) $display("FAIL ovf_full got %b want 1", stk_full); else passed++;
        total++; if (stk_err !== 1'b0) $display("FAIL ovf_err0 got %b want 0", stk_err); else passed++;
        D = 8'h50; tick();
        total++; if (PC_addr !== 8'h40) $display("FAIL ovf_pc got %h want 40", PC_addr); else passed++;
        total++; if (stk_err !== 1'b1) $display("FAIL ovf_err got %b want 1", stk_err); else passed++;
        idle(); RET = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (PC_addr !== rets[i]) $display("FAIL ovf_ret%0d got %h want %h", i, PC_addr, rets[i]);
            else passed++;
        end
        total++; if (stk_empty !== 1'b1) $display("FAIL ovf_empty got %b want 1", stk_empty); else passed++;
        tick();
        total++; if (PC_addr !== 8'h01) $display("FAIL unf_pc got %h want 01", PC_addr); else passed++;
        total++; if (stk_err !== 1'b1) $display("FAIL unf_err got %b want 1", stk_err); else passed++;
        idle();
    endtask

    task automatic test_priority();
        do_reset();
        CALL = 1; D = 8'h10; tick(); idle();
        LPC = 1; CALL = 1; RET = 1; IPC = 1; JREL = 1; OFS = 8'h07; D = 8'h80; tick();
        total++; if (PC_addr !== 8'h80) $display("FAIL prio_lpc got %h want 80", PC_addr); else passed++;
        total++; if (stk_empty !== 1'b0 || stk_full !== 1'b0)
            $display("FAIL prio_cnt got e%b f%b want e0 f0", stk_empty, stk_full); else passed++;
        idle(); CALL = 1; IPC = 1; D = 8'h90; tick();
        total++; if (PC_addr !== 8'h90) $display("FAIL prio_call got %h want 90", PC_addr); else passed++;
        idle(); RET = 1; JREL = 1; IPC = 1; OFS = 8'h40; tick();
        total++; if (PC_addr !== 8'h81) $display("FAIL prio_ret got %h want 81", PC_addr); else passed++;
        idle(); RET = 1; tick();
        total++; if (PC_addr !== 8'h01) $display("FAIL prio_ret2 got %h want 01", PC_addr); else passed++;
        idle(); JREL = 1; IPC = 1; OFS = 8'h10; tick();
        total++; if (PC_addr !== 8'h11) $display("FAIL prio_jrel got %h want 11", PC_addr); else passed++;
        total++; if (stk_err !== 1'b0 || stk_empty !== 1'b1)
            $display("FAIL prio_flags got err%b e%b want err0 e1", stk_err, stk_empty); else passed++;
        idle();
    endtask

    task automatic test_mid_reset();
        do_reset();
        CALL = 1; D = 8'h40; tick();
        D = 8'h60; tick();
        total++; if (PC_addr !== 8'h60) $display("FAIL mr_pre got %h want 60", PC_addr); else passed++;
        #3;
        CLRn = 1'b1;
        #1;
        total++; if (PC_addr !== 8'h00) $display("FAIL mr_pc got %h want 00", PC_addr); else passed++;
        total++; if (stk_empty !== 1'b1) $display("FAIL mr_empty got %b want 1", stk_empty); else passed++;
        total++; if (stk_err !== 1'b0) $display("FAIL mr_err got %b want 0", stk_err); else passed++;
        D = 8'h70; tick();
        total++; if (PC_addr !== 8'h00 || stk_empty !== 1'b1)
            $display("FAIL mr_ignore got %h/e%b want 00/e1", PC_addr, stk_empty); else passed++;
        CLRn = 1'b0;
        idle(); RET = 1; tick();
        total++; if (stk_err !== 1'b1) $display("FAIL mr_ret_err got %b want 1", stk_err); else passed++;
        total++; if (PC_addr !== 8'h00) $display("FAIL mr_ret_pc got %h want 00", PC_addr); else passed++;
        idle();
    endtask

    initial begin
        passed = 0;
        total  = 0;
        CLRn   = 1'b1;
        idle();
        test_reset();
        test_ipc_wrap();
        test_jrel();
        test_call_ret();
        test_overflow();
        test_priority();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pc_stack.md
PC_STACK -- requirements
Module: pc_stack

Interface
REQ-001 Parameter ADDR_W, default 8, program-counter and address width in bits (legal 4..16).
REQ-002 Parameter STK_DEPTH, default 4, return-stack entries (legal 2..16, power of two not required).
REQ-003 Parameter RESET_VEC, default 0, value loaded into PC_addr on reset.
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 CLRn  input  1  reset, asynchronous, active-high despite the name.
REQ-006 IPC  input  1  increment PC by 1.
REQ-007 LPC  input  1  absolute load: PC <= D.
REQ-008 JREL  input  1  relative jump: PC <= PC + sign-extended OFS.
REQ-009 CALL  input  1  push PC+1 onto return stack, PC <= D.
REQ-010 RET  input  1  pop return stack into PC.
REQ-011 D  input  ADDR_W  absolute target for LPC/CALL.
REQ-012 OFS  input  ADDR_W  two's-complement offset for JREL.
REQ-013 PC_addr  output  ADDR_W  current program counter, registered.
REQ-014 stk_full  output  1  return stack holds STK_DEPTH entries, combinational from count.
REQ-015 stk_empty  output  1  return stack holds 0 entries, combinational from count.
REQ-016 stk_err  output  1  sticky overflow/underflow flag, registered.

Function
REQ-017 The block SHALL update PC_addr only on rising clk; no combinational feedback path from PC_addr to itself.
REQ-018 Command priority SHALL be LPC > CALL > RET > JREL > IPC; only the highest asserted command acts per cycle, others ignored.
REQ-019 With no command asserted, PC_addr and stack SHALL hold.
REQ-020 IPC SHALL set PC_addr <= PC_addr+1 modulo 2^ADDR_W (all-ones wraps to 0, no flag).
REQ-021 JREL SHALL set PC_addr <= PC_addr+OFS modulo 2^ADDR_W; OFS=0 holds PC.
REQ-022 LPC SHALL set PC_addr <= D with stack untouched.
REQ-023 CALL when not full SHALL push (PC_addr+1) mod 2^ADDR_W and set PC_addr <= D in the same cycle; count +1.
REQ-024 CALL when full SHALL leave PC_addr and stack unchanged and set stk_err.
REQ-025 RET when not empty SHALL set PC_addr <= top entry and decrement count in the same cycle.
REQ-026 RET when empty SHALL leave PC_addr unchanged and set stk_err.
REQ-027 stk_err, once set, SHALL remain 1 until reset; it does not block further commands.
REQ-028 Command-to-PC_addr latency SHALL be exactly one clock; back-to-back commands every cycle SHALL be supported.
REQ-029 Stack SHALL be strict LIFO; nested CALLs to STK_DEPTH then equal RETs SHALL return addresses in reverse order.

Reset
REQ-030 CLRn=1 SHALL asynchronously force PC_addr=RESET_VEC, count=0 (stk_empty=1, stk_full=0), stk_err=0.
REQ-031 Reset asserted mid-sequence SHALL discard all stack contents; commands sampled while CLRn=1 SHALL be ignored.
REQ-032 First command after CLRn deasserts SHALL act on the first rising clk at which CLRn is low.

Structure
REQ-033 Shared package pc_pkg SHALL hold default ADDR_W, STK_DEPTH, RESET_VEC and the command-priority encoding constants.
REQ-034 Return stack SHALL be sub-module ret_stack (push, pop, data_in, top, full, empty, count) parametrised by ADDR_W and STK_DEPTH.
REQ-035 Stack storage SHALL be registers (no memory macro); entries need not be reset, only count.

Verification
REQ-036 Reset then IPC held 260 cycles (ADDR_W=8) -> PC_addr 0,1,...,255,0,1,2,3; stk_err stays 0.
REQ-037 PC=0x10, JREL with OFS=0xFC -> PC=0x0C; then OFS=0x05 -> PC=0x11; from 0xFE, OFS=0x03 -> 0x01.
REQ-038 PC=0x20: CALL D=0x40, CALL D=0x60, RET, RET -> PC 0x40, 0x60, 0x41, 0x21; stk_empty=1 at end.
REQ-039 STK_DEPTH=4: five CALLs -> after 4th stk_full=1; 5th leaves PC unchanged, stk_err=1; four RETs return correctly; 5th RET holds PC, stk_err still 1.
REQ-040 Same cycle LPC=1 D=0x80 with CALL=1, RET=1, IPC=1 -> PC=0x80, stack count unchanged; CALL+IPC -> call wins.
REQ-041 After two CALLs, assert CLRn mid-cycle (between edges) -> PC_addr=RESET_VEC immediately, stk_empty=1, stk_err=0; following RET sets stk_err.
